// File: rtl/usr_sequencer.sv
// Command-driven sequencer for a W-bit universal shift register (load/shr/shl/rotr with count).
// Define USR_SEQ_ROTATE_EN to enable op 11 as rotate-right; otherwise op 11 reports cmd_err.
module usr_sequencer #(
    parameter int unsigned W  = 4,
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [CW-1:0] cmd_count,
    input  logic [W-1:0]  cmd_data,
    input  logic          cmd_fill,
    input  logic [W-1:0]  usr_q,
    output logic [1:0]    usr_s,
    output logic [W-1:0]  usr_in,
    output logic          usr_msb,
    output logic          usr_lsb,
    output logic          busy,
    output logic          done,
    output logic          cmd_err
);

`ifdef USR_SEQ_ROTATE_EN
    localparam logic RotateEn = 1'b1;
`else
    localparam logic RotateEn = 1'b0;
`endif

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StLoad  = 2'd1;
    localparam logic [1:0] StShift = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [1:0] OpLoad = 2'b00;
    localparam logic [1:0] OpShr  = 2'b01;
    localparam logic [1:0] OpShl  = 2'b10;
    localparam logic [1:0] OpRotr = 2'b11;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] remaining_q, remaining_d;
    logic [1:0]    op_q, op_d;
    logic [W-1:0]  data_q, data_d;
    logic          fill_q, fill_d;

    // Only usr_q[0] is needed for rotation feedback.
    logic usr_q_unused;
    assign usr_q_unused = ^usr_q[W-1:1];

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        op_d        = op_q;
        data_d      = data_q;
        fill_d      = fill_q;
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    data_d = cmd_data;
                    fill_d = cmd_fill;
                    if (cmd_op == OpLoad) begin
                        state_d = StLoad;
                    end else if (cmd_op == OpRotr && !RotateEn) begin
                        state_d = StDone;
                    end else if (cmd_count != '0) begin
                        state_d     = StShift;
                        remaining_d = cmd_count;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StLoad: state_d = StDone;
            StShift: begin
                remaining_d = remaining_q - CW'(1);
                if (remaining_q <= CW'(1)) begin
                    state_d     = StDone;
                    remaining_d = '0;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            op_q        <= '0;
            data_q      <= '0;
            fill_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            op_q        <= op_d;
            data_q      <= data_d;
            fill_q      <= fill_d;
        end
    end

    always_comb begin
        usr_s   = 2'b00;
        usr_in  = data_q;
        usr_msb = 1'b0;
        usr_lsb = 1'b0;
        case (state_q)
            StLoad: usr_s = 2'b11;
            StShift: begin
                case (op_q)
                    OpShr: begin
                        usr_s   = 2'b01;
                        usr_msb = fill_q;
                    end
                    OpShl: begin
                        usr_s   = 2'b10;
                        usr_lsb = fill_q;
                    end
                    OpRotr: begin
                        if (RotateEn) begin
                            usr_s   = 2'b01;
                            usr_msb = usr_q[0];
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign cmd_err   = done && (op_q == OpRotr) && !RotateEn;

endmodule

// File: tb/tb_usr_sequencer.sv
// Self-checking bench for usr_sequencer: behavioural USR plus a per-cycle expected-trace model.
module tb_usr_sequencer;
    localparam int W  = 4;
    localparam int CW = 3;
`ifdef USR_SEQ_ROTATE_EN
    localparam bit RotEn = 1'b1;
`else
    localparam bit RotEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [CW-1:0] cmd_count;
    logic [W-1:0]  cmd_data;
    logic          cmd_fill;
    logic [W-1:0]  usr_q = '0;
    logic [1:0]    usr_s;
    logic [W-1:0]  usr_in;
    logic          usr_msb;
    logic          usr_lsb;
    logic          busy;
    logic          done;
    logic          cmd_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    usr_sequencer #(.W(W), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_count (cmd_count),
        .cmd_data  (cmd_data),
        .cmd_fill  (cmd_fill),
        .usr_q     (usr_q),
        .usr_s     (usr_s),
        .usr_in    (usr_in),
        .usr_msb   (usr_msb),
        .usr_lsb   (usr_lsb),
        .busy      (busy),
        .done      (done),
        .cmd_err   (cmd_err)
    );

    // The shift register being driven (not reset by the sequencer reset).
    always @(posedge clk) begin
        case (usr_s)
            2'b01:   usr_q <= {usr_msb, usr_q[W-1:1]};
            2'b10:   usr_q <= {usr_q[W-2:0], usr_lsb};
            2'b11:   usr_q <= usr_in;
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]   s;
        logic [W-1:0] din;
        logic         msb;
        logic         lsb;
        logic         dn;
        logic         err;
        logic [W-1:0] q;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] m_q    = '0;
    logic [W-1:0] m_data = '0;

    task automatic push(input logic [1:0] s, input logic [W-1:0] din, input logic msb,
                        input logic lsb, input logic dn, input logic err, input logic [W-1:0] q);
        exp_t e;
        e.s = s; e.din = din; e.msb = msb; e.lsb = lsb; e.dn = dn; e.err = err; e.q = q;
        exp_q.push_back(e);
    endtask

    // Expand one accepted command into the outputs expected on each following cycle.
    task automatic build(input logic [1:0] op, input logic [CW-1:0] cnt, input logic [W-1:0] data,
                         input logic fill);
        logic [W-1:0] cur;
        logic         err;
        cur    = m_q;
        err    = 1'b0;
        m_data = data;
        if (op == 2'b00) begin
            push(2'b11, data, 1'b0, 1'b0, 1'b0, 1'b0, cur);
            cur = data;
        end else if (op == 2'b11 && !RotEn) begin
            err = 1'b1;
        end else begin
            for (int i = 0; i < int'(cnt); i++) begin
                if (op == 2'b01) begin
                    push(2'b01, data, fill, 1'b0, 1'b0, 1'b0, cur);
                    cur = (cur >> 1) | (W'(fill) << (W - 1));
                end else if (op == 2'b10) begin
                    push(2'b10, data, 1'b0, fill, 1'b0, 1'b0, cur);
                    cur = (cur << 1) | W'(fill);
                end else begin
                    push(2'b01, data, cur[0], 1'b0, 1'b0, 1'b0, cur);
                    cur = (cur >> 1) | (W'(cur[0]) << (W - 1));
                end
            end
        end
        push(2'b00, data, 1'b0, 1'b0, 1'b1, err, cur);
        m_q = cur;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                check("idle_s", usr_s, 2'b00);
                check("idle_in", usr_in, m_data);
                check("idle_msb", usr_msb, 1'b0);
                check("idle_lsb", usr_lsb, 1'b0);
                check("idle_done", done, 1'b0);
                check("idle_err", cmd_err, 1'b0);
                check("idle_busy", busy, 1'b0);
                check("idle_ready", cmd_ready, 1'b1);
                check("idle_q", usr_q, m_q);
            end else begin
                check("s", usr_s, exp_q[0].s);
                check("in", usr_in, exp_q[0].din);
                check("msb", usr_msb, exp_q[0].msb);
                check("lsb", usr_lsb, exp_q[0].lsb);
                check("done", done, exp_q[0].dn);
                check("err", cmd_err, exp_q[0].err);
                check("busy", busy, 1'b1);
                check("ready", cmd_ready, 1'b0);
                check("q", usr_q, exp_q[0].q);
            end
            @(posedge clk);
            if (reset) begin
                if (exp_q.size() != 0) m_q = exp_q[0].q;
                exp_q.delete();
                m_data = '0;
            end else if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
            end else if (cmd_valid) begin
                build(cmd_op, cmd_count, cmd_data, cmd_fill);
            end
        end
    end

    task automatic drive_and_accept(input logic [1:0] op, input int count,
                                    input logic [W-1:0] data, input logic fill);
        @(negedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = CW'(count);
        cmd_data  = data;
        cmd_fill  = fill;
        for (int i = 0; i < 20 && !cmd_ready; i++) begin
            @(negedge clk);
            #1;
        end
        if (!cmd_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(negedge clk);
            if (done === 1'b1) lat = i;
        end
        check("done_seen", 32'(lat != 0), 32'd1);
    endtask

    task automatic run_cmd(input logic [1:0] op, input int count, input logic [W-1:0] data,
                           input logic fill, input int exp_lat, input bit has_q,
                           input logic [W-1:0] exp_qv);
        int lat;
        drive_and_accept(op, count, data, fill);
        // Scramble inputs after the accept edge; the command must run from latched fields.
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_count = CW'($urandom);
        cmd_data  = W'($urandom);
        cmd_fill  = 1'($urandom);
        wait_done(lat);
        if (exp_lat >= 0) check("latency", lat, exp_lat);
        if (has_q) begin
            @(negedge clk);
            check("q_after", usr_q, exp_qv);
        end
    endtask

    initial begin
        int lat;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_count = '0;
        cmd_data  = '0;
        cmd_fill  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_s", usr_s, 2'b00);
        check("rst_in", usr_in, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_done", done, 1'b0);
        #1 reset = 1'b0;

        run_cmd(2'b00, 0, 4'b1011, 1'b0, 2, 1'b1, 4'b1011);
        run_cmd(2'b01, 2, 4'b0000, 1'b1, 3, 1'b1, 4'b1110);
        run_cmd(2'b00, 0, 4'b1011, 1'b0, 2, 1'b1, 4'b1011);
        run_cmd(2'b10, 3, 4'b0000, 1'b0, 4, 1'b1, 4'b1000);
        run_cmd(2'b00, 0, 4'b1011, 1'b0, 2, 1'b1, 4'b1011);
        if (RotEn) begin
            run_cmd(2'b11, 1, 4'b0000, 1'b0, 2, 1'b1, 4'b1101);
            run_cmd(2'b00, 0, 4'b1011, 1'b0, 2, 1'b1, 4'b1011);
            run_cmd(2'b11, 4, 4'b0000, 1'b0, 5, 1'b1, 4'b1011);
        end else begin
            run_cmd(2'b11, 5, 4'b0000, 1'b0, 1, 1'b1, 4'b1011);
        end
        run_cmd(2'b01, 0, 4'b0000, 1'b1, 1, 1'b1, 4'b1011);

        // Held cmd_valid: second command starts after exactly one IDLE cycle.
        drive_and_accept(2'b01, 1, 4'b0000, 1'b1);
        wait_done(lat);
        check("held_lat1", lat, 2);
        wait_done(lat);
        check("held_lat2", lat, 3);
        #1 cmd_valid = 1'b0;

        // Asynchronous reset in the 2nd cycle of SHL count=5.
        run_cmd(2'b00, 0, 4'b1011, 1'b0, 2, 1'b1, 4'b1011);
        drive_and_accept(2'b10, 5, 4'b0000, 1'b1);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_s", usr_s, 2'b00);
        check("arst_busy", busy, 1'b0);
        check("arst_ready", cmd_ready, 1'b1);
        check("arst_done", done, 1'b0);
        @(negedge clk);
        #1 reset = 1'b0;
        check("arst_q", usr_q, 4'b0111);
        run_cmd(2'b00, 0, 4'b0101, 1'b0, 2, 1'b1, 4'b0101);
        run_cmd(2'b10, 2, 4'b0000, 1'b1, 3, 1'b1, 4'b0111);

        for (int n = 0; n < 80; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_cmd(2'($urandom), int'($urandom_range(0, 7)), W'($urandom), 1'($urandom),
                    -1, 1'b0, '0);
        end
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
